// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Purpose  : Command FIFO and result register in front of the 8-bit
//            combinational ALU. Also flags divide-by-zero results.
// Revision : 1.0  initial release
// ============================================================================
module alu_issue #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_a,
  input  logic [7:0]             in_b,
  input  logic [3:0]             in_op,
  output logic [7:0]             alu_a,
  output logic [7:0]             alu_b,
  output logic [3:0]             alu_op,
  input  logic [7:0]             alu_out,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [7:0]             res_data,
  output logic [3:0]             res_op,
  output logic                   res_dz,
  output logic [$clog2(DEPTH):0] count
);

  localparam int              c_AW      = $clog2(DEPTH);
  localparam int              c_CW      = c_AW + 1;
  localparam logic [c_CW-1:0] c_DEPTH   = c_CW'(DEPTH);
  localparam logic [3:0]      c_OP_DIV  = 4'b0011;
  localparam logic [0:0]      c_R_EMPTY = 1'b0;
  localparam logic [0:0]      c_R_FULL  = 1'b1;

  logic [7:0]      r_mem_a  [DEPTH];
  logic [7:0]      r_mem_b  [DEPTH];
  logic [3:0]      r_mem_op [DEPTH];
  logic [c_AW-1:0] r_wptr;
  logic [c_AW-1:0] r_rptr;
  logic [c_CW-1:0] r_count;
  logic [0:0]      r_state;
  logic [7:0]      r_res_data;
  logic [3:0]      r_res_op;
  logic            r_res_dz;

  logic            w_nonempty;
  logic            w_push;
  logic            w_issue;
  logic            w_div_zero;
  logic [7:0]      w_head_a;
  logic [7:0]      w_head_b;
  logic [3:0]      w_head_op;

  assign w_nonempty = (r_count != '0);
  assign in_ready   = (r_count < c_DEPTH);
  assign w_push     = in_valid & in_ready;
  // The result register frees up in the same cycle it is accepted downstream.
  assign w_issue    = w_nonempty & ((r_state == c_R_EMPTY) | res_ready);

  assign w_head_a   = r_mem_a[r_rptr];
  assign w_head_b   = r_mem_b[r_rptr];
  assign w_head_op  = r_mem_op[r_rptr];
  assign w_div_zero = (w_head_op == c_OP_DIV) && (w_head_b == 8'h00);

  assign alu_a  = w_nonempty ? w_head_a  : 8'h00;
  assign alu_b  = w_nonempty ? w_head_b  : 8'h00;
  assign alu_op = w_nonempty ? w_head_op : 4'h0;

  // Storage needs no reset: entries are only visible while count covers them.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wptr]  <= in_a;
      r_mem_b[r_wptr]  <= in_b;
      r_mem_op[r_wptr] <= in_op;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_issue) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_push, w_issue})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= c_R_EMPTY;
      r_res_data <= 8'h00;
      r_res_op   <= 4'h0;
      r_res_dz   <= 1'b0;
    end else if (w_issue) begin
      r_state  <= c_R_FULL;
      r_res_op <= w_head_op;
      if (w_div_zero) begin
        r_res_data <= 8'hFF;
        r_res_dz   <= 1'b1;
      end else begin
        r_res_data <= alu_out;
        r_res_dz   <= 1'b0;
      end
    end else if ((r_state == c_R_FULL) && res_ready) begin
      r_state <= c_R_EMPTY;
    end
  end

  assign res_valid = (r_state == c_R_FULL);
  assign res_data  = r_res_data;
  assign res_op    = r_res_op;
  assign res_dz    = r_res_dz;
  assign count     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_issue
// Purpose  : Directed bench for alu_issue with a queue-based reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_alu_issue;

  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic                   in_valid;
  logic                   in_ready;
  logic [7:0]             in_a;
  logic [7:0]             in_b;
  logic [3:0]             in_op;
  logic [7:0]             alu_a;
  logic [7:0]             alu_b;
  logic [3:0]             alu_op;
  logic [7:0]             alu_out;
  logic                   res_valid;
  logic                   res_ready;
  logic [7:0]             res_data;
  logic [3:0]             res_op;
  logic                   res_dz;
  logic [$clog2(DEPTH):0] count;

  int n_tests = 0;
  int n_fail  = 0;

  alu_issue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
    .res_op    (res_op),
    .res_dz    (res_dz),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Stand-in for the team ALU; division by zero returns 0 so the override is visible.
  function automatic logic [7:0] alu_f(input logic [7:0] a, input logic [7:0] b,
                                       input logic [3:0] op);
    case (op)
      4'h0:    return 8'(a + b);
      4'h1:    return 8'(a - b);
      4'h2:    return 8'(a * b);
      4'h3:    return (b == 8'h00) ? 8'h00 : a / b;
      4'h4:    return (b == 8'h00) ? 8'h00 : a % b;
      4'h5:    return a << b[2:0];
      4'h6:    return a >> b[2:0];
      4'h7:    return 8'(a + 8'd1);
      4'h8:    return a & b;
      4'h9:    return a | b;
      4'hA:    return a ^ b;
      4'hB:    return ~a;
      4'hC:    return ~(a & b);
      4'hD:    return {7'd0, a < b};
      4'hE:    return {7'd0, a > b};
      default: return {7'd0, a == b};
    endcase
  endfunction

  always_comb alu_out = alu_f(alu_a, alu_b, alu_op);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of pending commands plus one result slot.
  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
  } cmd_t;

  cmd_t       m_q[$];
  logic       m_rv;
  logic [7:0] m_data;
  logic [3:0] m_op;
  logic       m_dz;
  int         n_xfer;

  initial begin
    m_rv = 1'b0; m_data = 8'h00; m_op = 4'h0; m_dz = 1'b0; n_xfer = 0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_q.delete();
        m_rv = 1'b0; m_data = 8'h00; m_op = 4'h0; m_dz = 1'b0;
      end else begin
        bit   push;
        bit   issue;
        cmd_t h;
        push  = in_valid && (m_q.size() < DEPTH);
        issue = (m_q.size() > 0) && (!m_rv || res_ready);
        if (m_rv && res_ready) n_xfer++;
        if (issue) begin
          h    = m_q.pop_front();
          m_op = h.op;
          if (h.op == 4'd3 && h.b == 8'h00) begin
            m_data = 8'hFF; m_dz = 1'b1;
          end else begin
            m_data = alu_f(h.a, h.b, h.op); m_dz = 1'b0;
          end
          m_rv = 1'b1;
        end else if (m_rv && res_ready) begin
          m_rv = 1'b0;
        end
        if (push) m_q.push_back({in_a, in_b, in_op});
      end
    end
  end

  always @(negedge clk) begin
    check("cyc_in_ready", in_ready, m_q.size() < DEPTH);
    check("cyc_count", count, m_q.size());
    check("cyc_res_valid", res_valid, m_rv);
    check("cyc_res_data", res_data, m_data);
    check("cyc_res_op", res_op, m_op);
    check("cyc_res_dz", res_dz, m_dz);
    check("cyc_alu_a", alu_a, (m_q.size() > 0) ? m_q[0].a : 8'h00);
    check("cyc_alu_b", alu_b, (m_q.size() > 0) ? m_q[0].b : 8'h00);
    check("cyc_alu_op", alu_op, (m_q.size() > 0) ? m_q[0].op : 4'h0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    in_valid = 1'b1; in_a = a; in_b = b; in_op = op;
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    in_valid  = 1'b0;
    res_ready = 1'b1;
    while ((count != '0 || res_valid) && k < 50) begin
      tick();
      k++;
    end
    check(name, k < 50, 1'b1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int sent;
    int cyc;
    int x0;
    logic acc_now;

    in_valid = 1'b0; in_a = 8'h00; in_b = 8'h00; in_op = 4'h0; res_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_count", count, 0);
    check("rst_alu_a", alu_a, 8'h00);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b0;

    // Back-to-back add/sub/mul with 2-cycle latency.
    res_ready = 1'b1;
    send(8'h27, 8'hB8, 4'h0); tick();
    check("t1_not_yet_valid", res_valid, 1'b0);
    check("t1_count1", count, 1);
    send(8'h27, 8'hB8, 4'h1); tick();
    check("t1_r0_valid", res_valid, 1'b1);
    check("t1_r0_data", res_data, 8'hDF);
    check("t1_r0_dz", res_dz, 1'b0);
    send(8'h27, 8'hB8, 4'h2); tick();
    check("t1_r1_data", res_data, 8'h6F);
    in_valid = 1'b0; tick();
    check("t1_r2_data", res_data, 8'h08);
    check("t1_r2_op", res_op, 4'h2);
    check("t1_r2_dz", res_dz, 1'b0);
    tick();
    check("t1_drained", res_valid, 1'b0);

    // Divide-by-zero flag, then a non-divide with b == 0.
    send(8'h27, 8'h00, 4'h3); tick();
    send(8'h27, 8'h00, 4'h8); tick();
    check("t2_dz_data", res_data, 8'hFF);
    check("t2_dz_flag", res_dz, 1'b1);
    check("t2_dz_op", res_op, 4'h3);
    in_valid = 1'b0; tick();
    check("t2_and_data", res_data, 8'h00);
    check("t2_and_dz", res_dz, 1'b0);
    tick();

    // Backpressure: DEPTH+1 commands fit.
    res_ready = 1'b0;
    acc = 0;
    for (int i = 1; i <= 6; i++) begin
      send(8'(i), 8'h01, 4'h0);
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    check("t3_accepted", acc, 5);
    check("t3_count", count, 4);
    check("t3_in_ready", in_ready, 1'b0);
    check("t3_res_data", res_data, 8'h02);
    tick(); tick();
    check("t3_hold_data", res_data, 8'h02);
    check("t3_hold_valid", res_valid, 1'b1);
    res_ready = 1'b1; tick();
    check("t3_d1_data", res_data, 8'h03);
    check("t3_d1_in_ready", in_ready, 1'b1);
    check("t3_d1_count", count, 3);
    tick(); check("t3_d2_data", res_data, 8'h04);
    tick(); check("t3_d3_data", res_data, 8'h05);
    tick(); check("t3_d4_data", res_data, 8'h06);
    tick(); check("t3_empty", res_valid, 1'b0);

    // Pointer wrap with alternating downstream readiness.
    x0 = n_xfer; sent = 0; cyc = 0;
    while (sent < 10 && cyc < 200) begin
      send(8'(sent * 37 + 5), 8'(sent % 3), 4'(sent * 5));
      res_ready = cyc[0];
      acc_now = in_ready;
      tick();
      if (acc_now) sent++;
      cyc++;
    end
    in_valid = 1'b0;
    while ((count != '0 || res_valid) && cyc < 200) begin
      res_ready = cyc[0];
      tick();
      cyc++;
    end
    check("t4_no_timeout", cyc < 200, 1'b1);
    check("t4_count0", count, 0);
    check("t4_valid0", res_valid, 1'b0);
    check("t4_xfers", n_xfer - x0, 10);

    // Simultaneous push and pop at count == 2.
    res_ready = 1'b0;
    send(8'h10, 8'h01, 4'h0); tick();
    send(8'h20, 8'h01, 4'h0); tick();
    send(8'h30, 8'h01, 4'h0); tick();
    check("t5_count_pre", count, 2);
    check("t5_head_pre", alu_a, 8'h20);
    res_ready = 1'b1;
    send(8'h40, 8'h01, 4'h0); tick();
    in_valid = 1'b0;
    check("t5_count_post", count, 2);
    check("t5_head_post", alu_a, 8'h30);
    check("t5_res", res_data, 8'h21);
    drain("t5_drain");

    // Asynchronous reset with queued work and a held result.
    res_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      send(8'(i + 8), 8'h03, 4'h0);
      tick();
    end
    in_valid = 1'b0;
    check("t6_count3", count, 3);
    check("t6_valid", res_valid, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_valid", res_valid, 1'b0);
    check("t6_rst_count", count, 0);
    check("t6_rst_in_ready", in_ready, 1'b1);
    check("t6_rst_alu_a", alu_a, 8'h00);
    check("t6_rst_data", res_data, 8'h00);
    @(negedge clk); @(negedge clk);
    #2 rst = 1'b0;
    res_ready = 1'b1;
    send(8'h01, 8'h02, 4'h0); tick();
    in_valid = 1'b0; tick();
    check("t6_fresh_valid", res_valid, 1'b1);
    check("t6_fresh_data", res_data, 8'h03);
    drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
